// File: rtl/dram_host_master.sv
// rtl/dram_host_master.sv - host command master and refresh scheduler for the DRAM model
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid/req_ready       host request handshake
//   req_write/row/col/wdata   request fields, latched on the handshake
//   rsp_valid/rsp_rdata/err   one-cycle response strobe, data and error code
//   temp                      die temperature; selects the refresh period
//   ref_err                   sticky refresh error flag
//   busy                      operation in progress
//   dram_opcode/row/column/data_in  command pins driven to the DRAM
//   dram_data_out/dram_error        DRAM response pins
//
// Optional feature: DRAM_MASTER_PARITY_EN adds even-parity generation on
// write data bit 31 and a parity check on read data.

module dram_host_master #(
    parameter int          RESP_LAT     = 2,
    parameter int          REF_INTERVAL = 1000,
    parameter logic [7:0]  HOT_TEMP     = 8'd85
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [9:0]  req_row,
    input  logic [9:0]  req_col,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_err,
    input  logic [7:0]  temp,
    output logic        ref_err,
    output logic        busy,
    output logic [1:0]  dram_opcode,
    output logic [9:0]  dram_row,
    output logic [9:0]  dram_column,
    output logic [31:0] dram_data_in,
    input  logic [31:0] dram_data_out,
    input  logic [1:0]  dram_error
);

    localparam int             RCW      = $clog2(REF_INTERVAL + 1);
    localparam logic [RCW-1:0] REF_FULL = RCW'(REF_INTERVAL);
    localparam logic [RCW-1:0] REF_HALF = RCW'(REF_INTERVAL / 2);
    localparam logic [RCW-1:0] REF_ONE  = RCW'(1);
    localparam logic [3:0]     LAT      = 4'(RESP_LAT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [3:0]     wait_cnt;
    logic [RCW-1:0] ref_cnt;
    logic           ref_due;
    logic           start_ref;
    logic           start_host;
    logic           op_is_ref;
    logic           op_write;
    logic           sample_now;
    logic [31:0]    wdata_coded;
    logic           rd_parity_err;

`ifdef DRAM_MASTER_PARITY_EN
    // Bit 31 carries the parity of the lower 31 bits so the word has even parity.
    assign wdata_coded   = {^req_wdata[30:0], req_wdata[30:0]};
    assign rd_parity_err = ^dram_data_out;
`else
    assign wdata_coded   = req_wdata;
    assign rd_parity_err = 1'b0;
`endif

    // The refresh counter saturates at zero, so "due" is simply "counter empty".
    assign ref_due    = (ref_cnt == '0);
    assign req_ready  = (state == ST_IDLE) && !ref_due;
    assign busy       = (state != ST_IDLE);
    assign sample_now = (state == ST_WAIT) && (wait_cnt == LAT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        start_ref   = 1'b0;
        start_host  = 1'b0;
        dram_opcode = 2'b00;
        rsp_valid   = 1'b0;
        case (state)
            ST_IDLE: begin
                // Refresh wins over a pending host request.
                if (ref_due) begin
                    start_ref  = 1'b1;
                    state_next = ST_ISSUE;
                end else if (req_valid) begin
                    start_host = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                dram_opcode = op_is_ref ? 2'b11 : (op_write ? 2'b10 : 2'b01);
                state_next  = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_cnt == LAT) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                rsp_valid  = !op_is_ref;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt     <= 4'd0;
            ref_cnt      <= REF_FULL;
            op_is_ref    <= 1'b0;
            op_write     <= 1'b0;
            dram_row     <= 10'd0;
            dram_column  <= 10'd0;
            dram_data_in <= 32'd0;
            rsp_rdata    <= 32'd0;
            rsp_err      <= 2'b00;
            ref_err      <= 1'b0;
        end else begin
            // Temperature is sampled only at reload, so a change takes effect
            // from the next refresh onward.
            if (start_ref) begin
                ref_cnt <= (temp >= HOT_TEMP) ? REF_HALF : REF_FULL;
            end else if (ref_cnt != '0) begin
                ref_cnt <= ref_cnt - REF_ONE;
            end

            if (start_ref) begin
                op_is_ref <= 1'b1;
            end else if (start_host) begin
                op_is_ref    <= 1'b0;
                op_write     <= req_write;
                dram_row     <= req_row;
                dram_column  <= req_col;
                dram_data_in <= wdata_coded;
            end

            if (state == ST_ISSUE) begin
                wait_cnt <= 4'd1;
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt + 4'd1;
            end

            // Capture on the last WAIT cycle; responses hold until the next host DONE.
            if (sample_now) begin
                if (op_is_ref) begin
                    if (dram_error != 2'b00) begin
                        ref_err <= 1'b1;
                    end
                end else begin
                    rsp_rdata <= op_write ? 32'd0 : dram_data_out;
                    rsp_err   <= {(op_write ? 1'b0 : rd_parity_err), (dram_error != 2'b00)};
                end
            end
        end
    end

endmodule

// File: tb/tb_dram_host_master.sv
// tb/tb_dram_host_master.sv - self-checking bench for dram_host_master

module tb_dram_host_master;

    localparam int LAT = 2;
    localparam int RI  = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [9:0]  req_row;
    logic [9:0]  req_col;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic [7:0]  temp;
    logic        ref_err;
    logic        busy;
    logic [1:0]  dram_opcode;
    logic [9:0]  dram_row;
    logic [9:0]  dram_column;
    logic [31:0] dram_data_in;
    logic [31:0] dram_data_out;
    logic [1:0]  dram_error;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rsp_count = 0;
    logic prev_ready = 1'b0;
    int   ref_times[$];
    logic ref_prev_ready[$];
    logic [9:0]  last_row = 10'd0;
    logic [9:0]  last_col = 10'd0;
    logic [31:0] last_din = 32'd0;

    dram_host_master #(.RESP_LAT(LAT), .REF_INTERVAL(RI), .HOT_TEMP(8'd85)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_row(req_row), .req_col(req_col), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .temp(temp), .ref_err(ref_err), .busy(busy),
        .dram_opcode(dram_opcode), .dram_row(dram_row), .dram_column(dram_column),
        .dram_data_in(dram_data_in), .dram_data_out(dram_data_out), .dram_error(dram_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (dram_opcode == 2'b11) begin
                ref_times.push_back(cyc);
                ref_prev_ready.push_back(prev_ready);
            end
            if (rsp_valid) rsp_count <= rsp_count + 1;
        end
        prev_ready <= req_ready;
    end

    function automatic logic [31:0] model_din(input logic [31:0] wd);
`ifdef DRAM_MASTER_PARITY_EN
        return {^wd[30:0], wd[30:0]};
`else
        return wd;
`endif
    endfunction

    function automatic logic model_rpar(input logic [31:0] d);
`ifdef DRAM_MASTER_PARITY_EN
        return ^d;
`else
        return 1'b0;
`endif
    endfunction

    // Entered and left at a falling edge.
    task automatic host_op(input logic w, input logic [9:0] row, input logic [9:0] col,
                           input logic [31:0] wd, input logic [31:0] dout,
                           input logic [1:0] derr, output int hs_cyc);
        int n;
        logic [31:0] exp_rd;
        logic [1:0]  exp_err;
        exp_rd  = w ? 32'd0 : dout;
        exp_err = {(w ? 1'b0 : model_rpar(dout)), (derr != 2'b00)};
        hs_cyc = -1;
        req_valid = 1'b1; req_write = w; req_row = row; req_col = col; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (!req_ready) begin
            errors++; $display("FAIL handshake_timeout ready=%b required=1", req_ready);
            req_valid = 1'b0;
            return;
        end
        hs_cyc = cyc;
        dram_data_out = dout; dram_error = derr;
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (dram_opcode !== (w ? 2'b10 : 2'b01)) begin
            errors++; $display("FAIL issue_opcode got=%b required=%b", dram_opcode, (w ? 2'b10 : 2'b01));
        end
        checks++;
        if (dram_row !== row || dram_column !== col || dram_data_in !== model_din(wd)) begin
            errors++; $display("FAIL issue_fields got=%h/%h/%h required=%h/%h/%h",
                               dram_row, dram_column, dram_data_in, row, col, model_din(wd));
        end
        last_row = row; last_col = col; last_din = model_din(wd);
        for (int i = 0; i < LAT; i++) begin
            @(negedge clk);
            checks++;
            if (dram_opcode !== 2'b00 || rsp_valid !== 1'b0 || busy !== 1'b1) begin
                errors++; $display("FAIL wait_phase op=%b rsp_valid=%b busy=%b required 00/0/1",
                                   dram_opcode, rsp_valid, busy);
            end
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rd || rsp_err !== exp_err) begin
            errors++; $display("FAIL response got v=%b d=%h e=%b required v=1 d=%h e=%b",
                               rsp_valid, rsp_rdata, rsp_err, exp_rd, exp_err);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_rdata !== exp_rd || rsp_err !== exp_err) begin
            errors++; $display("FAIL after_done got v=%b busy=%b d=%h e=%b required v=0 busy=0 d=%h e=%b",
                               rsp_valid, busy, rsp_rdata, rsp_err, exp_rd, exp_err);
        end
        dram_error = 2'b00; dram_data_out = $urandom;
    endtask

    task automatic test_reset;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_row = 10'd0; req_col = 10'd0;
        req_wdata = 32'd0; temp = 8'd30; dram_data_out = 32'd0; dram_error = 2'b00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (dram_opcode !== 2'b00 || busy !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ctrl op=%b busy=%b ready=%b required 00/0/1", dram_opcode, busy, req_ready);
        end
        checks++;
        if (dram_row !== 10'd0 || dram_column !== 10'd0 || dram_data_in !== 32'd0) begin
            errors++; $display("FAIL reset_addr got %h/%h/%h required 0", dram_row, dram_column, dram_data_in);
        end
        checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 2'b00 || ref_err !== 1'b0) begin
            errors++; $display("FAIL reset_rsp got v=%b d=%h e=%b ref_err=%b required 0", rsp_valid, rsp_rdata, rsp_err, ref_err);
        end
    endtask

    task automatic test_directed;
        int h;
        host_op(1'b1, 10'd5, 10'd10, 32'h19973111, 32'h0, 2'b00, h);
        host_op(1'b0, 10'd5, 10'd10, 32'h0, 32'h99973111, 2'b00, h);
        host_op(1'b0, 10'd5, 10'd10, 32'h0, 32'h89973111, 2'b00, h);
        host_op(1'b1, 10'd1023, 10'd0, 32'hFFFFFFFF, 32'h12345678, 2'b01, h);
        host_op(1'b0, 10'd0, 10'd1023, 32'h0, 32'h00000000, 2'b10, h);
    endtask

    task automatic test_random_ops;
        int h;
        for (int i = 0; i < 12; i++) begin
            temp = 8'($urandom_range(0, 84));
            host_op(1'($urandom), 10'($urandom), 10'($urandom), $urandom, $urandom,
                    (($urandom % 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00, h);
        end
        temp = 8'd30;
    endtask

    task automatic test_back_to_back;
        int n;
        int h1;
        int h2;
        n = 0;
        while (dram_opcode !== 2'b11 && n < 100) begin @(negedge clk); n++; end
        n = 0;
        while (busy !== 1'b0 && n < 20) begin @(negedge clk); n++; end
        host_op(1'b1, 10'd7, 10'd8, $urandom, $urandom, 2'b00, h1);
        host_op(1'b0, 10'd9, 10'd3, $urandom, $urandom, 2'b00, h2);
        checks++;
        if (h2 - h1 !== LAT + 3) begin
            errors++; $display("FAIL throughput got=%0d required=%0d", h2 - h1, LAT + 3);
        end
    endtask

    task automatic check_intervals(input string tag, input int qs, input int lo, input int hi);
        int n;
        n = 0;
        while (ref_times.size() < qs + 3 && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (ref_times.size() < qs + 3) begin
            errors++; $display("FAIL %s_timeout pulses=%0d required=%0d", tag, ref_times.size() - qs, 3);
            return;
        end
        for (int i = qs + 1; i < qs + 3; i++) begin
            checks++;
            if (ref_times[i] - ref_times[i-1] < lo || ref_times[i] - ref_times[i-1] > hi) begin
                errors++; $display("FAIL %s_interval got=%0d required=%0d..%0d", tag,
                                   ref_times[i] - ref_times[i-1], lo, hi);
            end
            checks++;
            if (ref_prev_ready[i] !== 1'b0) begin
                errors++; $display("FAIL %s_ready_when_due got=%b required=0", tag, ref_prev_ready[i]);
            end
        end
    endtask

    task automatic test_refresh_interval;
        req_valid = 1'b0;
        temp = 8'd30;
        repeat (2) @(negedge clk);
        check_intervals("cold", ref_times.size(), RI, RI + 2);
        temp = 8'd90;
        repeat (2) @(negedge clk);
        check_intervals("hot", ref_times.size(), RI / 2, RI / 2 + 2);
        temp = 8'd30;
        repeat (RI) @(negedge clk);
    endtask

    task automatic test_priority;
        int n;
        logic [31:0] wd;
        wd = $urandom;
        n = 0;
        while (!(busy === 1'b0 && req_ready === 1'b0) && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (!(busy === 1'b0 && req_ready === 1'b0)) begin
            errors++; $display("FAIL prio_due_timeout busy=%b ready=%b required 0/0", busy, req_ready);
            return;
        end
        req_valid = 1'b1; req_write = 1'b1; req_row = 10'd77; req_col = 10'd66; req_wdata = wd;
        dram_error = 2'b01;
        @(negedge clk);
        checks++;
        if (dram_opcode !== 2'b11 || dram_row !== last_row || dram_column !== last_col || dram_data_in !== last_din) begin
            errors++; $display("FAIL prio_refresh_first op=%b row=%h col=%h din=%h required 11/%h/%h/%h",
                               dram_opcode, dram_row, dram_column, dram_data_in, last_row, last_col, last_din);
        end
        repeat (LAT) @(negedge clk);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || ref_err !== 1'b1) begin
            errors++; $display("FAIL prio_refresh_done rsp_valid=%b ref_err=%b required 0/1", rsp_valid, ref_err);
        end
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL prio_ready_after got=%b required=1", req_ready);
        end
        dram_error = 2'b00;
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (dram_opcode !== 2'b10 || dram_row !== 10'd77 || dram_data_in !== model_din(wd)) begin
            errors++; $display("FAIL prio_host_follows op=%b row=%h din=%h required 10/04d/%h",
                               dram_opcode, dram_row, dram_data_in, model_din(wd));
        end
        last_row = 10'd77; last_col = 10'd66; last_din = model_din(wd);
        repeat (LAT) @(negedge clk);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 2'b00 || rsp_rdata !== 32'd0) begin
            errors++; $display("FAIL prio_host_rsp v=%b e=%b d=%h required 1/00/0", rsp_valid, rsp_err, rsp_rdata);
        end
        n = 0;
        while (dram_opcode !== 2'b11 && n < 100) begin @(negedge clk); n++; end
        repeat (LAT + 3) @(negedge clk);
        checks++;
        if (ref_err !== 1'b1) begin
            errors++; $display("FAIL ref_err_sticky got=%b required=1", ref_err);
        end
    endtask

    task automatic test_reset_midop;
        int n;
        int rc0;
        int h;
        n = 0;
        req_valid = 1'b1; req_write = 1'b0; req_row = 10'd3; req_col = 10'd4; req_wdata = 32'd0;
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        dram_data_out = 32'hCAFEF00D;
        @(negedge clk);
        req_valid = 1'b0;
        rc0 = rsp_count;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (dram_opcode !== 2'b00 || busy !== 1'b0 || ref_err !== 1'b0) begin
            errors++; $display("FAIL midop_reset op=%b busy=%b ref_err=%b required 00/0/0", dram_opcode, busy, ref_err);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (LAT + 3) @(negedge clk);
        #1;
        checks++;
        if (rsp_count !== rc0) begin
            errors++; $display("FAIL midop_no_rsp got=%0d required=%0d", rsp_count, rc0);
        end
        @(negedge clk);
        n = 0;
        req_valid = 1'b1; req_write = 1'b1; req_wdata = 32'h5;
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (dram_opcode !== 2'b00 || busy !== 1'b0) begin
            errors++; $display("FAIL issue_reset op=%b busy=%b required 00/0", dram_opcode, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        host_op(1'b0, 10'd11, 10'd12, 32'h0, 32'h0F0F0F0F, 2'b00, h);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random_ops();
        test_back_to_back();
        test_refresh_interval();
        test_priority();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dram_host_master.md
# dram_host_master

Host-side command master for the Micron DRAM model. It accepts read and write requests from a host over a valid/ready handshake and drives the model's opcode/row/column/data pins as single-cycle command pulses. After a fixed response latency it captures the returned data and error code. It also schedules temperature-aware refresh commands autonomously. It sits between the system logic and the DRAM model and is the only agent that drives the model's command inputs.

## Interface
Parameters:
- RESP_LAT, 2: number of cycles the master waits after the opcode pulse before it samples the DRAM outputs (legal range 1..15).
- REF_INTERVAL, 1000: refresh period in cycles at normal temperature (≥ 4).
- HOT_TEMP, 8'd85: temperature threshold; when temp ≥ HOT_TEMP the refresh period is halved.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  host request valid
- req_ready  out  1  master can accept a request
- req_write  in  1  1 = write, 0 = read
- req_row  in  10  row address
- req_col  in  10  column address
- req_wdata  in  32  write data; bit 31 is ignored when parity is enabled
- rsp_valid  out  1  one-cycle response strobe for both reads and writes
- rsp_rdata  out  32  captured read data (0 for writes)
- rsp_err  out  2  bit0 = DRAM reported an error; bit1 = read parity failure
- temp  in  8  die temperature
- ref_err  out  1  sticky flag; set when a refresh completes with a DRAM error
- busy  out  1  state machine is not in IDLE
- dram_opcode  out  2  00 idle, 01 read, 10 write, 11 refresh
- dram_row  out  10  row driven to the DRAM
- dram_column  out  10  column driven to the DRAM
- dram_data_in  out  32  write data driven to the DRAM
- dram_data_out  in  32  read data from the DRAM
- dram_error  in  2  error code from the DRAM; any nonzero value is an error

## Operation
- States:
  - IDLE: no operation in progress.
  - ISSUE: the opcode is driven for exactly 1 cycle.
  - WAIT: lasts RESP_LAT cycles; the opcode is 00.
  - DONE: lasts 1 cycle; rsp_valid is asserted for host operations.
- Transitions:
  - IDLE to ISSUE on a refresh-due condition or a handshake (req_valid && req_ready).
  - ISSUE to WAIT.
  - WAIT to DONE when its counter reaches RESP_LAT.
  - DONE to IDLE.
- Request latching: row, column, data and direction are latched into registers on the handshake. dram_row, dram_column and dram_data_in hold their values from ISSUE through DONE.
- Sampling: dram_data_out and dram_error are sampled on the last WAIT cycle.
- req_ready = (state == IDLE) && !ref_due.
- Refresh counter:
  - Down-counter; loaded with REF_INTERVAL at reset.
  - At every reload it samples temp: the load value is REF_INTERVAL/2 when temp ≥ HOT_TEMP, otherwise REF_INTERVAL.
  - Decrements each cycle. At 0 it sets ref_due and holds at 0.
  - On entering ISSUE for a refresh, it reloads and clears ref_due.
- Priority: refresh beats a host request when both are present in IDLE. A refresh that falls due mid-transaction is deferred to the next IDLE.
- Refresh operations:
  - Drive opcode 11, with row/column/data held at their last values.
  - No rsp_valid.
  - A nonzero dram_error sets ref_err. ref_err is cleared only by rst.
- Write response: rsp_rdata = 0, rsp_err[1] = 0.

## Timing
- Handshake accepted at cycle T:
  - T+1: dram_opcode driven (01 or 10).
  - T+2 … T+1+RESP_LAT: WAIT.
  - T+2+RESP_LAT: rsp_valid = 1.
  - T+3+RESP_LAT: req_ready returns to 1 (back in IDLE).
- Throughput: one operation per RESP_LAT+3 cycles.
- Reset values:
  - state IDLE, dram_opcode 00.
  - All data/address outputs 0.
  - rsp_valid 0, rsp_err 00, ref_err 0, busy 0.
  - req_ready is 1 after reset deasserts.
- Reset mid-operation aborts immediately:
  - dram_opcode is forced to 00 asynchronously.
  - No rsp_valid is emitted for the aborted request.
- rsp_* outputs hold their values until the next DONE. rsp_valid is high for exactly 1 cycle.

## Configuration
- DRAM_MASTER_PARITY_EN defined:
  - Writes: dram_data_in[31] = ^req_wdata[30:0], so the 32-bit word has even overall parity.
  - Reads: rsp_err[1] = ^dram_data_out (odd overall parity is a failure).
- DRAM_MASTER_PARITY_EN undefined:
  - dram_data_in = req_wdata unchanged.
  - rsp_err[1] is tied to 0.

## Test plan
- Parity-enabled write (parity enabled): row 5, column 10, req_wdata 0x19973111 → opcode 10 for one cycle with dram_data_in = 0x99973111; rsp_valid at T+4 (RESP_LAT 2) with rsp_err = 00.
- Read, valid data: dram_data_out = 0x99973111, dram_error = 00 → rsp_rdata = 0x99973111, rsp_err = 00.
- Read, parity failure: dram_data_out = 0x89973111 → rsp_err[1] = 1.
- Refresh interval vs temperature (REF_INTERVAL 20):
  - temp 30 → opcode 11 every 20+ cycles.
  - temp 90 → after the next reload, opcode 11 every 10+ cycles.
  - req_ready is low while ref_due is set.
- Priority and error flags: refresh due in the same cycle as req_valid → refresh is issued first and the request follows. A DRAM error (dram_error = 01) during the refresh sets ref_err, which stays set.
- Reset mid-operation: assert rst during WAIT → dram_opcode 00 and busy 0 immediately; no rsp_valid; next request completes normally.
